// File: rtl/cdc_debounce_edge.sv
`default_nettype none
// ============================================================================
// Module      : cdc_debounce_edge
// Description : Debounce filter for an already-synchronized bit. Produces a
//               filtered level plus registered one-cycle rise/fall strobes
//               and an abort strobe when a pending change is cancelled.
//               Filtering is counted in tick-qualified samples.
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_debounce_edge #(
  parameter int   STABLE_COUNT = 4,
  parameter logic RESET_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic d_sync,
  output logic q,
  output logic rise,
  output logic fall,
  output logic abort
);

  localparam int CNT_WIDTH = $clog2(STABLE_COUNT);

  localparam logic [0:0] ST_STABLE  = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  // Terminal count: the sample that completes the filter window.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);

  logic [0:0]           state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 differs;

  assign differs = (d_sync != q);

  // Filter state machine; strobes default low so each lasts one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_STABLE;
      cnt   <= '0;
      q     <= RESET_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
      abort <= 1'b0;
    end else begin
      rise  <= 1'b0;
      fall  <= 1'b0;
      abort <= 1'b0;
      case (state)
        ST_STABLE: begin
          if (differs) begin
            state <= ST_PENDING;
            // An unqualified first sample starts the window without counting.
            cnt   <= tick ? CNT_WIDTH'(1) : '0;
          end
        end
        ST_PENDING: begin
          if (!differs) begin
            // Input returned to the held level before the window completed.
            state <= ST_STABLE;
            cnt   <= '0;
            abort <= 1'b1;
          end else if (tick) begin
            if (cnt == CNT_LAST) begin
              state <= ST_STABLE;
              cnt   <= '0;
              q     <= d_sync;
              rise  <= d_sync;
              fall  <= ~d_sync;
            end else begin
              cnt <= cnt + CNT_WIDTH'(1);
            end
          end
        end
        default: begin
          state <= ST_STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdc_debounce_edge.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdc_debounce_edge
// Description : Directed self-checking bench for cdc_debounce_edge with
//               STABLE_COUNT=4 and RESET_LEVEL=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_debounce_edge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b1;
  logic d_sync = 1'b0;
  logic q, rise, fall, abort;

  int checks = 0;
  int errors = 0;

  cdc_debounce_edge #(
    .STABLE_COUNT(4),
    .RESET_LEVEL (1'b0)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .d_sync(d_sync),
    .q     (q),
    .rise  (rise),
    .fall  (fall),
    .abort (abort)
  );

  always #5 clk = ~clk;

  // Advance one active edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Put the DUT into a known q=level state.
  task automatic establish(input logic level);
    rst = 1'b1; d_sync = 1'b0; tick = 1'b1;
    step(); step();
    rst = 1'b0;
    if (level) begin
      d_sync = 1'b1;
      for (int i = 0; i < 5; i++) step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; d_sync = 1'b1; tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({q, rise, fall, abort} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d q/r/f/a=%b exp=0000", i, {q, rise, fall, abort});
      end
    end
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      logic [3:0] exp;
      step();
      exp = (e < 4) ? 4'b0000 : (e == 4) ? 4'b1100 : 4'b1000;
      checks++;
      if ({q, rise, fall, abort} !== exp) begin
        errors++;
        $display("FAIL reset_release edge=%0d q/r/f/a=%b exp=%b", e, {q, rise, fall, abort}, exp);
      end
    end
  endtask

  task automatic test_rise();
    establish(1'b0);
    d_sync = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      logic [3:0] exp;
      step();
      exp = (e < 4) ? 4'b0000 : (e == 4) ? 4'b1100 : 4'b1000;
      checks++;
      if ({q, rise, fall, abort} !== exp) begin
        errors++;
        $display("FAIL rise edge=%0d q/r/f/a=%b exp=%b", e, {q, rise, fall, abort}, exp);
      end
    end
  endtask

  task automatic test_glitch_abort();
    establish(1'b0);
    d_sync = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step();
      checks++;
      if ({q, rise, fall, abort} !== 4'b0000) begin
        errors++;
        $display("FAIL glitch_hold edge=%0d q/r/f/a=%b exp=0000", e, {q, rise, fall, abort});
      end
    end
    d_sync = 1'b0;
    step();
    checks++;
    if ({q, rise, fall, abort} !== 4'b0001) begin
      errors++;
      $display("FAIL glitch_abort q/r/f/a=%b exp=0001", {q, rise, fall, abort});
    end
    for (int e = 0; e < 3; e++) begin
      step();
      checks++;
      if ({q, rise, fall, abort} !== 4'b0000) begin
        errors++;
        $display("FAIL glitch_after edge=%0d q/r/f/a=%b exp=0000", e, {q, rise, fall, abort});
      end
    end
  endtask

  task automatic test_tick_prescale();
    establish(1'b0);
    // Rise with ticks at edges 2,5,8,11; first differing sample is unqualified.
    d_sync = 1'b1;
    for (int i = 0; i < 13; i++) begin
      logic [3:0] exp;
      tick = (i % 3 == 2);
      step();
      exp = (i < 11) ? 4'b0000 : (i == 11) ? 4'b1100 : 4'b1000;
      checks++;
      if ({q, rise, fall, abort} !== exp) begin
        errors++;
        $display("FAIL tick_rise i=%0d q/r/f/a=%b exp=%b", i, {q, rise, fall, abort}, exp);
      end
    end
    // Partial fall window (one tick), then input returns between ticks.
    d_sync = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick = (i % 3 == 2);
      step();
    end
    d_sync = 1'b1; tick = 1'b0;
    step();
    checks++;
    if ({q, rise, fall, abort} !== 4'b1001) begin
      errors++;
      $display("FAIL tick_abort q/r/f/a=%b exp=1001", {q, rise, fall, abort});
    end
    // Count must restart from zero: fall only on the 4th fresh tick.
    d_sync = 1'b0;
    for (int i = 0; i < 13; i++) begin
      logic [3:0] exp;
      tick = (i % 3 == 2);
      step();
      exp = (i < 11) ? 4'b1000 : (i == 11) ? 4'b0010 : 4'b0000;
      checks++;
      if ({q, rise, fall, abort} !== exp) begin
        errors++;
        $display("FAIL tick_fall i=%0d q/r/f/a=%b exp=%b", i, {q, rise, fall, abort}, exp);
      end
    end
    tick = 1'b1;
  endtask

  task automatic test_fall();
    establish(1'b1);
    checks++;
    if ({q, rise, fall, abort} !== 4'b1000) begin
      errors++;
      $display("FAIL fall_start q/r/f/a=%b exp=1000", {q, rise, fall, abort});
    end
    d_sync = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      logic [3:0] exp;
      step();
      exp = (e < 4) ? 4'b1000 : (e == 4) ? 4'b0010 : 4'b0000;
      checks++;
      if ({q, rise, fall, abort} !== exp) begin
        errors++;
        $display("FAIL fall edge=%0d q/r/f/a=%b exp=%b", e, {q, rise, fall, abort}, exp);
      end
    end
  endtask

  task automatic test_reset_mid_pending();
    establish(1'b0);
    d_sync = 1'b1;
    step(); step();
    rst = 1'b1;
    step();
    checks++;
    if ({q, rise, fall, abort} !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_reset q/r/f/a=%b exp=0000", {q, rise, fall, abort});
    end
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      logic [3:0] exp;
      step();
      exp = (e < 4) ? 4'b0000 : (e == 4) ? 4'b1100 : 4'b1000;
      checks++;
      if ({q, rise, fall, abort} !== exp) begin
        errors++;
        $display("FAIL midrst_release edge=%0d q/r/f/a=%b exp=%b", e, {q, rise, fall, abort}, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch_abort();
    test_tick_prescale();
    test_fall();
    test_reset_mid_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
